candy_avb_pio_ext: RTL
======================

# candy_avb_pio_ext

Parametrised Avalon-MM general-purpose I/O port, the next generation of the single-bit output PIO used in the Qsys system. Provides up to 32 bidirectional pins with per-bit direction, atomic set/clear of output bits, synchronised inputs with edge capture, and a maskable interrupt. Sits as a zero-wait-state slave on the CPU data master, driving board LEDs, codec control lines and button inputs.

## Interface

- WIDTH, 8: number of pins, 1..32.
- RESET_VALUE, 0: reset value of the output data register, WIDTH bits.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- EDGE_TYPE, 0: capture edge; 0 rising, 1 falling, 2 any.
- IRQ_TYPE, 1: 0 level (masked synchronised input), 1 edge (masked edge-capture register).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  read data; bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  per-bit output enable, equal to the direction register.
- irq  out  1  interrupt request, active high.

## Operation

- Register map:
  - 0 DATA: read returns (out_port & dir) | (sync_in & ~dir); write loads data_out.
  - 1 DIR: 1 = output; read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read; write-1-to-clear.
  - 4 OUTSET: write-1-sets data_out bits; reads 0.
  - 5 OUTCLR: write-1-clears data_out bits; reads 0.
  - 6–7: read 0; writes ignored.
- Input path: in_port passes through SYNC_STAGES flops to give sync_in. A further flop holds sync_prev. Edge detection:
  - rising: sync_in & ~sync_prev
  - falling: ~sync_in & sync_prev
  - any: sync_in ^ sync_prev
- Edges are detected on all bits regardless of DIR.
- Warm-up: a counter holds edge detection off for SYNC_STAGES+1 cycles after reset release, so a pin held high through reset never captures a spurious rising edge.
- EDGECAP bit n sets on a detected edge and holds until cleared by a write of 1. If the set and the clear occur in the same cycle, the set wins.
- irq condition:
  - IRQ_TYPE=1: |(edgecap & mask)
  - IRQ_TYPE=0: |(sync_in & mask)
- Reset values: data_out=RESET_VALUE, dir=0 (all inputs, oe=0), mask=0, edgecap=0, synchroniser and sync_prev=0, warm-up counter=0, irq=0.

## Timing

- Reads: combinational from address (read latency 0, no wait states). readdata reflects register state as of the current cycle.
- Writes: take effect at the rising clk edge of the write cycle. out_port and oe update in the following cycle, and the next read sees the new value.
- Pin to readback: an in_port change is visible in DATA after SYNC_STAGES clock edges.
- Pin to EDGECAP: the capture bit sets at edge SYNC_STAGES+1.
- irq is registered: it asserts one cycle after its condition becomes true and deasserts one cycle after the condition becomes false (mask cleared or EDGECAP cleared).
- Reset asserted mid-operation clears all state immediately (asynchronously). The warm-up counter restarts on reset release.

## Structure

- Package candy_avb_pio_pkg holds:
  - register offset constants: ADDR_DATA, ADDR_DIR, ADDR_IRQMASK, ADDR_EDGECAP, ADDR_OUTSET, ADDR_OUTCLR
  - EDGE_RISING, EDGE_FALLING, EDGE_ANY
  - IRQ_LEVEL, IRQ_EDGE
- Sub-module candy_avb_pio_sync_edge (parameters WIDTH, SYNC_STAGES, EDGE_TYPE) contains the synchroniser, sync_prev, warm-up counter and edge vector.
- The top level contains only the register file, read mux and irq flop.

## Test plan

- Reset with RESET_VALUE=8'hA5 → out_port=8'hA5, oe=0, irq=0, all reads 0 except DATA, which reads sync_in.
- Write DIR=8'h0F, DATA=8'h3C, then OUTSET=8'h01, then OUTCLR=8'h04 → out_port sequence 3C, 3D, 39. DATA reads (39&0F)|(in&F0).
- EDGE_TYPE=0, in_port bit 5 driven 0→1 → EDGECAP=8'h20 at edge SYNC_STAGES+1. With mask bit 5 set, irq=1 one cycle later. Writing EDGECAP=8'h20 drops irq the cycle after the write.
- Write-1-clear of bit 2 in the same cycle as a new edge on bit 2 → bit 2 remains 1 and irq stays asserted.
- in_port=8'hFF held through reset release → EDGECAP stays 0 after warm-up. IRQ_TYPE=0 with mask=8'h80 → irq=1 after SYNC_STAGES+1 cycles.
- Assert reset_n low mid-capture, with EDGECAP=8'h10 and irq=1 → immediate clear of EDGECAP, irq and out_port (to RESET_VALUE), independent of clk.

Source files
------------

// File: rtl/candy_avb_pio_pkg.sv
// Shared constants for the candy_avb_pio_ext GPIO port: register offsets and
// the encodings of the edge-capture and interrupt modes.
package candy_avb_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/candy_avb_pio_sync_edge.sv
// Input synchroniser, one-cycle history flop and edge detector, with a
// warm-up window that suppresses edges until the chain holds real pin data.
module candy_avb_pio_sync_edge
    import candy_avb_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_det,
    output logic             warm_done
);

    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] WARM_LAST = CW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_prev;
    logic [CW-1:0]    warm_cnt;
    logic [WIDTH-1:0] raw_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sync_prev <= '0;
            warm_cnt  <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sync_prev <= sync_q[SYNC_STAGES-1];
            if (warm_cnt != WARM_LAST) warm_cnt <= warm_cnt + CW'(1);
        end
    end

    assign sync_in   = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_cnt == WARM_LAST);

    always_comb begin
        raw_edge = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  raw_edge = sync_in & ~sync_prev;
            EDGE_FALLING: raw_edge = ~sync_in & sync_prev;
            default:      raw_edge = sync_in ^ sync_prev;
        endcase
    end

    // A pin held high through reset looks like a rising edge once the chain
    // fills; the warm-up gate hides exactly that first transition.
    assign edge_det = warm_done ? raw_edge : '0;

endmodule

// File: rtl/candy_avb_pio_ext.sv
// Avalon-MM GPIO slave: data/direction/mask/edge-capture registers,
// combinational read mux and a registered interrupt.
module candy_avb_pio_ext
    import candy_avb_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = EDGE_RISING,
    parameter int               IRQ_TYPE    = IRQ_EDGE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    // Bus: zero-wait-state slave. A write is chipselect && !write_n and is
    // committed at that cycle's rising edge; reads are a pure function of
    // address and current register state, so there is no stall path.
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_out, dir, mask, edgecap;
    logic [WIDTH-1:0] sync_in, edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rd_val;
    logic             irq_cond;
    logic             warm_done;

    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    candy_avb_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_port   (in_port),
        .sync_in   (sync_in),
        .edge_det  (edge_det),
        .warm_done (warm_done)
    );

    assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
            dir      <= '0;
            mask     <= '0;
            edgecap  <= '0;
            irq      <= 1'b0;
        end else begin
            // New edges are OR-ed after the clear so a coincident edge survives.
            edgecap <= (edgecap & ~cap_clr) | edge_det;
            irq     <= irq_cond;
            if (wr_en) begin
                case (address)
                    ADDR_DATA:    data_out <= wdata;
                    ADDR_DIR:     dir      <= wdata;
                    ADDR_IRQMASK: mask     <= wdata;
                    ADDR_OUTSET:  data_out <= data_out | wdata;
                    ADDR_OUTCLR:  data_out <= data_out & ~wdata;
                    default: ;
                endcase
            end
        end
    end

    generate
        if (IRQ_TYPE == IRQ_EDGE) begin : g_irq_edge
            assign irq_cond = |(edgecap & mask);
        end else begin : g_irq_level
            assign irq_cond = |(sync_in & mask);
        end
    endgenerate

    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA:    rd_val = (data_out & dir) | (sync_in & ~dir);
            ADDR_DIR:     rd_val = dir;
            ADDR_IRQMASK: rd_val = mask;
            ADDR_EDGECAP: rd_val = edgecap;
            default:      rd_val = '0;
        endcase
    end

    assign readdata = 32'(rd_val);
    assign out_port = data_out;
    assign oe       = dir;

endmodule
